// File: rtl/uart_ram_loader_pkg.sv
// Processor-wide constants and the UART receiver state encoding shared by
// the boot loader blocks.
package uart_ram_loader_pkg;

    localparam int UART_CLKS_PER_BIT = 434;  // 50 MHz / 115200 baud
    localparam int RAM_ADDR_W        = 8;
    localparam int PROGRAM_LEN       = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_ram_loader_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM, one-cycle
// byte strobe and a sticky framing-error flag.
module uart_rx
    import uart_ram_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST_C  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST_C = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_meta;
    logic             rx_s;
    rx_state_t        state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       bit_cnt, bit_cnt_d;
    logic [7:0]       shift, shift_d;
    logic [7:0]       rx_byte_d;
    logic             rx_valid_d;
    logic             frame_err_d;

    // Synchroniser idles high so reset never looks like a start bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            bit_cnt   <= bit_cnt_d;
            shift     <= shift_d;
            rx_byte   <= rx_byte_d;
            rx_valid  <= rx_valid_d;
            frame_err <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        bit_cnt_d   = bit_cnt;
        shift_d     = shift;
        rx_byte_d   = rx_byte;
        rx_valid_d  = 1'b0;
        frame_err_d = frame_err;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                // Re-check the start bit at its centre to reject line glitches
                if (cnt == HALF_LAST_C) begin
                    cnt_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST_C) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift[7:1]};
                    bit_cnt_d = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST_C) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx_s) begin
                        rx_valid_d = 1'b1;
                        rx_byte_d  = shift;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_ram_loader.sv
// Boot loader: receives LOAD_LEN bytes over UART and writes them to RAM from
// address 0, then flags completion so the control unit may start fetching.
module uart_ram_loader
    import uart_ram_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int ADDR_W       = RAM_ADDR_W,
    parameter int LOAD_LEN     = PROGRAM_LEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              uart2ram_completed,
    output logic              frame_err,
    output logic [ADDR_W:0]   bytes_loaded
);

    localparam logic [ADDR_W:0] LEN_C = (ADDR_W + 1)'(LOAD_LEN);

    logic       rx_vld_p0;
    logic [7:0] rx_byte_p0;
    logic       accept;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_valid (rx_vld_p0),
        .rx_byte  (rx_byte_p0),
        .frame_err(frame_err)
    );

    // Count guard keeps a late byte out even in the cycle before the flag rises
    assign accept = rx_vld_p0 && !uart2ram_completed && (bytes_loaded < LEN_C);

    // Write stage: one strobe per accepted byte, address/data held between writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_we             <= 1'b0;
            ram_addr           <= '0;
            ram_wdata          <= '0;
            bytes_loaded       <= '0;
            uart2ram_completed <= 1'b0;
        end else begin
            ram_we <= accept;
            if (accept) begin
                ram_addr     <= bytes_loaded[ADDR_W-1:0];
                ram_wdata    <= rx_byte_p0;
                bytes_loaded <= bytes_loaded + 1'b1;
            end
            if (ram_we && (bytes_loaded == LEN_C)) begin
                uart2ram_completed <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_ram_loader.sv
// Directed bench for uart_ram_loader with a write scoreboard: stimulus pushes
// expected RAM writes, a monitor pops and compares on each ram_we strobe.
module tb_uart_ram_loader;

    localparam int CPB  = 4;
    localparam int CPB5 = 5;
    localparam int AW   = 2;
    localparam int LEN  = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
        bit            last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx = 1'b1;
    logic          rx5 = 1'b1;
    logic          ram_we, ram_we5;
    logic [AW-1:0] ram_addr, ram_addr5;
    logic [7:0]    ram_wdata, ram_wdata5;
    logic          completed, completed5;
    logic          frame_err, frame_err5;
    logic [AW:0]   bytes_loaded, bytes_loaded5;

    exp_t exp_q[$];
    exp_t exp5_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    bit   done_pending = 0;

    always #5 clk = ~clk;

    uart_ram_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .LOAD_LEN(LEN)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .uart2ram_completed(completed), .frame_err(frame_err),
        .bytes_loaded(bytes_loaded)
    );

    uart_ram_loader #(.CLKS_PER_BIT(CPB5), .ADDR_W(AW), .LOAD_LEN(LEN)) dut5 (
        .clk(clk), .rst_n(rst_n), .rx(rx5),
        .ram_we(ram_we5), .ram_addr(ram_addr5), .ram_wdata(ram_wdata5),
        .uart2ram_completed(completed5), .frame_err(frame_err5),
        .bytes_loaded(bytes_loaded5)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_line(input int which, input logic v);
        if (which == 5) rx5 = v;
        else            rx  = v;
    endtask

    task automatic hold_bit(input int which, input logic v);
        set_line(which, v);
        repeat ((which == 5) ? CPB5 : CPB) @(negedge clk);
    endtask

    task automatic send_frame(input int which, input logic [7:0] d, input logic stop);
        hold_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) hold_bit(which, d[i]);
        hold_bit(which, stop);
        set_line(which, 1'b1);
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [7:0] d, input bit last);
        exp_t e;
        e.addr = a; e.data = d; e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rx = 1'b1;
        rx5 = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Monitor for the CPB=4 instance
    always @(negedge clk) begin
        exp_t e;
        if (done_pending) begin
            chk("completed_after_last_we", {31'd0, completed}, 32'd1);
            done_pending = 0;
        end
        if (ram_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {31'd0, ram_we}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("ram_addr", {30'd0, ram_addr}, {30'd0, e.addr});
                chk("ram_wdata", {24'd0, ram_wdata}, {24'd0, e.data});
                if (e.last) begin
                    chk("completed_low_at_last_we", {31'd0, completed}, 32'd0);
                    done_pending = 1;
                end
            end
        end
    end

    // Monitor for the CPB=5 instance
    always @(negedge clk) begin
        exp_t e;
        if (ram_we5) begin
            if (exp5_q.size() == 0) begin
                chk("unexpected_write5", {31'd0, ram_we5}, 32'd0);
            end else begin
                e = exp5_q.pop_front();
                chk("ram_addr5", {30'd0, ram_addr5}, {30'd0, e.addr});
                chk("ram_wdata5", {24'd0, ram_wdata5}, {24'd0, e.data});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        exp_t e5;
        // Reset state
        rst_n = 1'b0;
        #12;
        chk("rst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("rst_ram_addr", {30'd0, ram_addr}, 32'd0);
        chk("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
        chk("rst_completed", {31'd0, completed}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_bytes_loaded", {29'd0, bytes_loaded}, 32'd0);
        do_reset();

        // Single byte
        push(2'd0, 8'hA5, 0);
        send_frame(0, 8'hA5, 1'b1);
        repeat (6) @(negedge clk);
        chk("a5_bytes_loaded", {29'd0, bytes_loaded}, 32'd1);
        chk("a5_completed", {31'd0, completed}, 32'd0);
        chk("a5_frame_err", {31'd0, frame_err}, 32'd0);

        // Full load back-to-back, then an ignored extra byte
        do_reset();
        push(2'd0, 8'h01, 0);
        push(2'd1, 8'h02, 0);
        push(2'd2, 8'h03, 0);
        push(2'd3, 8'h04, 1);
        send_frame(0, 8'h01, 1'b1);
        send_frame(0, 8'h02, 1'b1);
        send_frame(0, 8'h03, 1'b1);
        send_frame(0, 8'h04, 1'b1);
        repeat (6) @(negedge clk);
        chk("load_bytes_loaded", {29'd0, bytes_loaded}, 32'd4);
        chk("load_completed", {31'd0, completed}, 32'd1);
        send_frame(0, 8'hFF, 1'b1);
        repeat (6) @(negedge clk);
        chk("post_done_bytes_loaded", {29'd0, bytes_loaded}, 32'd4);
        chk("post_done_completed", {31'd0, completed}, 32'd1);

        // One-cycle glitch
        do_reset();
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_frame_err", {31'd0, frame_err}, 32'd0);
        chk("glitch_bytes_loaded", {29'd0, bytes_loaded}, 32'd0);

        // Framing error, then a good byte continues at address 0
        send_frame(0, 8'h3C, 1'b0);
        repeat (3 * CPB) @(negedge clk);
        chk("ferr_frame_err", {31'd0, frame_err}, 32'd1);
        chk("ferr_bytes_loaded", {29'd0, bytes_loaded}, 32'd0);
        push(2'd0, 8'h55, 0);
        send_frame(0, 8'h55, 1'b1);
        repeat (6) @(negedge clk);
        chk("after_ferr_bytes_loaded", {29'd0, bytes_loaded}, 32'd1);
        chk("after_ferr_frame_err", {31'd0, frame_err}, 32'd1);

        // Reset in the middle of the third byte
        do_reset();
        push(2'd0, 8'h11, 0);
        push(2'd1, 8'h22, 0);
        send_frame(0, 8'h11, 1'b1);
        send_frame(0, 8'h22, 1'b1);
        repeat (6) @(negedge clk);
        hold_bit(0, 1'b0);
        hold_bit(0, 1'b1);
        hold_bit(0, 1'b0);
        hold_bit(0, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_ram_we", {31'd0, ram_we}, 32'd0);
        chk("midrst_ram_addr", {30'd0, ram_addr}, 32'd0);
        chk("midrst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
        chk("midrst_completed", {31'd0, completed}, 32'd0);
        chk("midrst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("midrst_bytes_loaded", {29'd0, bytes_loaded}, 32'd0);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        push(2'd0, 8'h77, 0);
        send_frame(0, 8'h77, 1'b1);
        repeat (6) @(negedge clk);
        chk("rst_reload_bytes_loaded", {29'd0, bytes_loaded}, 32'd1);

        // Odd bit period on the second instance
        e5.addr = 2'd0; e5.data = 8'h81; e5.last = 0;
        exp5_q.push_back(e5);
        send_frame(5, 8'h81, 1'b1);
        repeat (6) @(negedge clk);
        chk("odd_bytes_loaded", {29'd0, bytes_loaded5}, 32'd1);
        chk("odd_frame_err", {31'd0, frame_err5}, 32'd0);

        repeat (4) @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 32'd0);
        chk("exp5_q_drained", exp5_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
